// File: rtl/instr_sequencer.sv
// Decode/issue stage in front of the 4x4 datapath: turns 16-bit instructions into a registered
// ControlWord/ConstantIn pair, with WAIT/HALT sequencing. Optional issue counter under PERF_CNT_EN.
module instr_sequencer #(
  parameter int WAIT_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              hold,
  output logic [12:0]       ControlWord,
`ifdef PERF_CNT_EN
  output logic [CNT_W-1:0]  issue_cnt,
`endif
  output logic [3:0]        ConstantIn,
  output logic              halted,
  output logic              illegal
);

  localparam logic [12:0] NOP_WORD = 13'h0001;

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_HALTED
  } state_t;

  state_t              state, state_d;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_d;
  logic [12:0]         cw_d;
  logic [3:0]          const_d;
  logic                accept;

  logic [3:0] op;
  logic [1:0] da, aa, ba;
  logic [3:0] imm;
  logic       unused_rsvd;

  assign op          = instr[15:12];
  assign da          = instr[11:10];
  assign aa          = instr[9:8];
  assign ba          = instr[7:6];
  assign imm         = instr[3:0];
  assign unused_rsvd = ^instr[5:4];

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state       <= S_RUN;
      wait_cnt    <= '0;
      ControlWord <= NOP_WORD;
      ConstantIn  <= 4'h0;
      illegal     <= 1'b0;
    end else begin
      state       <= state_d;
      wait_cnt    <= wait_cnt_d;
      ControlWord <= cw_d;
      ConstantIn  <= const_d;
      if (accept && op == 4'hE)
        illegal <= 1'b1;
    end
  end

  // WAIT N stays in S_WAIT for N cycles; the count keeps running even under hold.
  always_comb begin
    state_d    = state;
    wait_cnt_d = wait_cnt;
    case (state)
      S_RUN: begin
        if (accept && op == 4'hD && imm != 4'h0) begin
          state_d    = S_WAIT;
          wait_cnt_d = WAIT_W'(imm);
        end else if (accept && op == 4'hF) begin
          state_d = S_HALTED;
        end
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt - WAIT_W'(1);
        if (wait_cnt <= WAIT_W'(1))
          state_d = S_RUN;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RUN;
    endcase
  end

  always_comb begin
    instr_ready = nRST & (state == S_RUN) & ~hold;
    accept      = instr_valid & instr_ready;
    halted      = (state == S_HALTED);
    cw_d        = NOP_WORD;
    const_d     = ConstantIn;
    if (accept && op >= 4'h1 && op <= 4'hC) begin
      cw_d    = {da, aa, ba, 1'b0, 4'b0000, 1'b0, 1'b0};
      const_d = imm;
      case (op)
        4'h1:    cw_d[5:2] = 4'b0000;
        4'h2:    cw_d[5:2] = 4'b0001;
        4'h3:    cw_d[5:2] = 4'b0010;
        4'h4:    cw_d[5:2] = 4'b0101;
        4'h5:    cw_d[5:2] = 4'b0110;
        4'h6:    cw_d[5:2] = 4'b1000;
        4'h7:    cw_d[5:2] = 4'b1001;
        4'h8:    cw_d[5:2] = 4'b1010;
        4'h9:    cw_d[5:2] = 4'b1011;
        4'hA:    begin cw_d[5:2] = 4'b1100; cw_d[6] = 1'b1; end
        4'hB:    begin cw_d[5:2] = 4'b0010; cw_d[6] = 1'b1; end
        4'hC:    cw_d[1] = 1'b1;
        default: cw_d = NOP_WORD;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!nRST)
      issue_cnt <= '0;
    else if (accept && op >= 4'h1 && op <= 4'hC)
      issue_cnt <= issue_cnt + CNT_W'(1);
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: hand-computed ControlWord/ConstantIn vectors plus
// WAIT, hold, illegal, HALT and reset sequences.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        nRST;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        hold;
  logic [12:0] ControlWord;
  logic [3:0]  ConstantIn;
  logic        halted;
  logic        illegal;
`ifdef PERF_CNT_EN
  logic [7:0]  issue_cnt;
`endif

  int checks = 0;
  int errors = 0;

  instr_sequencer #(.WAIT_W(4), .CNT_W(8)) dut (
    .clk         (clk),
    .nRST        (nRST),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .hold        (hold),
    .ControlWord (ControlWord),
`ifdef PERF_CNT_EN
    .issue_cnt   (issue_cnt),
`endif
    .ConstantIn  (ConstantIn),
    .halted      (halted),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] i, input logic v);
    instr       = i;
    instr_valid = v;
  endtask

  // Back-to-back table: instruction, expected ControlWord, expected ConstantIn.
  logic [15:0] vec_instr [11] = '{16'h1E43, 16'h2500, 16'h4000, 16'h5000, 16'h6000, 16'h7000,
                                  16'h8000, 16'h9000, 16'hB0F7, 16'hC400, 16'h0000};
  logic [12:0] vec_cw    [11] = '{13'h1C80, 13'h0A04, 13'h0014, 13'h0018, 13'h0020, 13'h0024,
                                  13'h0028, 13'h002C, 13'h01C8, 13'h0802, 13'h0001};
  logic [3:0]  vec_const [11] = '{4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                                  4'h0, 4'h0, 4'h7, 4'h0, 4'h0};

  initial begin
    nRST = 1'b0;
    hold = 1'b0;
    applyStimulus(16'h0000, 1'b0);
    tick();
    tick();
    checkOutput("rst_cw", 16'(ControlWord), 16'h0001);
    checkOutput("rst_const", 16'(ConstantIn), 16'h0);
    checkOutput("rst_halted", 16'(halted), 16'h0);
    checkOutput("rst_illegal", 16'(illegal), 16'h0);
    checkOutput("rst_ready_low", 16'(instr_ready), 16'h0);
    nRST = 1'b1;
    #1;
    checkOutput("ready_after_rst", 16'(instr_ready), 16'h1);

    applyStimulus(16'h3D80, 1'b1);
    tick();
    checkOutput("add_cw", 16'(ControlWord), 16'h1B08);
    applyStimulus(16'h3D80, 1'b0);
    tick();
    checkOutput("add_then_nop", 16'(ControlWord), 16'h0001);

    applyStimulus(16'hA809, 1'b1);
    tick();
    checkOutput("ldi_cw", 16'(ControlWord), 16'h1070);
    checkOutput("ldi_const", 16'(ConstantIn), 16'h9);

    // WAIT 3 followed immediately by an ADD held valid
    applyStimulus(16'hD003, 1'b1);
    tick();
    applyStimulus(16'h34C5, 1'b1);
    checkOutput("wait_nop0", 16'(ControlWord), 16'h0001);
    checkOutput("wait_const_hold", 16'(ConstantIn), 16'h9);
    checkOutput("wait_ready0", 16'(instr_ready), 16'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkOutput($sformatf("wait_nop%0d", i), 16'(ControlWord), 16'h0001);
      checkOutput($sformatf("wait_ready%0d", i), 16'(instr_ready), (i == 3) ? 16'h1 : 16'h0);
    end
    tick();
    checkOutput("after_wait_cw", 16'(ControlWord), 16'h0988);
    checkOutput("after_wait_const", 16'(ConstantIn), 16'h5);

    applyStimulus(16'hD000, 1'b1);
    tick();
    applyStimulus(16'hD000, 1'b0);
    checkOutput("wait0_cw", 16'(ControlWord), 16'h0001);
    checkOutput("wait0_ready", 16'(instr_ready), 16'h1);

    hold = 1'b1;
    applyStimulus(16'h3D80, 1'b1);
    #1;
    checkOutput("hold_ready", 16'(instr_ready), 16'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput($sformatf("hold_nop%0d", i), 16'(ControlWord), 16'h0001);
      checkOutput($sformatf("hold_ready%0d", i), 16'(instr_ready), 16'h0);
    end
    hold = 1'b0;
    #1;
    checkOutput("unhold_ready", 16'(instr_ready), 16'h1);
    tick();
    checkOutput("unhold_cw", 16'(ControlWord), 16'h1B08);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vec_instr[i], 1'b1);
      tick();
      checkOutput($sformatf("vec%0d_cw", i), 16'(ControlWord), 16'(vec_cw[i]));
      if (i != 10)
        checkOutput($sformatf("vec%0d_const", i), 16'(ConstantIn), 16'(vec_const[i]));
    end
    applyStimulus(16'h0000, 1'b0);

    // Mid-WAIT reset must bring the sequencer straight back to RUN
    applyStimulus(16'hD00F, 1'b1);
    tick();
    applyStimulus(16'h0000, 1'b0);
    tick();
    checkOutput("midwait_ready", 16'(instr_ready), 16'h0);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    #1;
    checkOutput("midwait_rst_ready", 16'(instr_ready), 16'h1);

    applyStimulus(16'hE000, 1'b1);
    tick();
    checkOutput("illegal_cw", 16'(ControlWord), 16'h0001);
    checkOutput("illegal_set", 16'(illegal), 16'h1);
    applyStimulus(16'h3D80, 1'b1);
    tick();
    checkOutput("illegal_next_cw", 16'(ControlWord), 16'h1B08);
    applyStimulus(16'h3D80, 1'b0);
    tick();
    checkOutput("illegal_sticky", 16'(illegal), 16'h1);
`ifdef PERF_CNT_EN
    checkOutput("issue_cnt", 16'(issue_cnt), 16'h1);
`endif

    applyStimulus(16'hF000, 1'b1);
    tick();
    applyStimulus(16'h3D80, 1'b1);
    checkOutput("halt_halted", 16'(halted), 16'h1);
    checkOutput("halt_ready", 16'(instr_ready), 16'h0);
    tick();
    tick();
    checkOutput("halt_stay_cw", 16'(ControlWord), 16'h0001);
    checkOutput("halt_stay", 16'(halted), 16'h1);
`ifdef PERF_CNT_EN
    checkOutput("halt_issue_cnt", 16'(issue_cnt), 16'h1);
`endif
    nRST = 1'b0;
    tick();
    applyStimulus(16'h0000, 1'b0);
    checkOutput("halt_rst_halted", 16'(halted), 16'h0);
    checkOutput("halt_rst_cw", 16'(ControlWord), 16'h0001);
    checkOutput("halt_rst_illegal", 16'(illegal), 16'h0);
    nRST = 1'b1;
    #1;
    checkOutput("halt_rst_ready", 16'(instr_ready), 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Control stage that sits directly upstream of the 4x4-bit register-file/function-unit datapath.
- Accepts 16-bit instructions over a valid/ready handshake and decodes each one into the datapath's 13-bit ControlWord and 4-bit ConstantIn.
- Handles multi-cycle WAIT and terminal HALT with a small FSM. Outputs are registered, so the datapath sees stable control for one full cycle per instruction.

Parameters:
- WAIT_W, 4: width of the WAIT down-counter; must be >= 4 (imm field width).
- CNT_W, 8: width of the issue counter (used only with PERF_CNT_EN).

Ports:
- clk  in  1  system clock, rising edge
- nRST  in  1  synchronous active-low reset
- instr  in  16  instruction: [15:12] op, [11:10] DA, [9:8] AA, [7:6] BA, [5:4] rsvd (ignored), [3:0] imm
- instr_valid  in  1  instr is valid this cycle
- instr_ready  out  1  sequencer can accept an instruction this cycle
- hold  in  1  stall request; forces NOP issue and blocks acceptance
- ControlWord  out  13  {DA[12:11], AA[10:9], BA[8:7], MB[6], FS[5:2], MD[1], nWE[0]}, registered
- ConstantIn  out  4  immediate to datapath, registered
- halted  out  1  HALT executed
- illegal  out  1  sticky: reserved opcode seen

Behaviour:
- Reset (nRST=0 at a rising edge):
  - ControlWord=13'h0001 (NOP: nWE=1, all else 0), ConstantIn=0, halted=0, illegal=0.
  - State=RUN, wait counter=0, instr_ready=0 while nRST=0.
- NOP word is defined as 13'h0001. Any cycle that does not issue an instruction drives NOP, and ConstantIn holds its last value.
- instr_ready = nRST & (state==RUN) & ~hold. This is combinational from state and hold.
- Accept occurs when instr_valid & instr_ready at a rising edge. The decoded word appears on ControlWord after that same edge (1-cycle latency) and lasts exactly one cycle unless the next instruction is accepted back-to-back. Full throughput is 1 instruction per cycle.
- Decode rules for ops that write the register file (nWE=0):
  - DA/AA/BA copied from the instruction fields; ConstantIn=imm.
  - MB=0 and MD=0 unless stated otherwise below.
- Op to FS mapping:
  - 0 NOP: NOP word.
  - 1 MOV: FS=0000.
  - 2 INC: FS=0001.
  - 3 ADD: FS=0010.
  - 4 SUB: FS=0101.
  - 5 DEC: FS=0110.
  - 6 AND: FS=1000.
  - 7 OR: FS=1001.
  - 8 XOR: FS=1010.
  - 9 NOT: FS=1011.
  - A LDI: FS=1100, MB=1.
  - B ADDI: FS=0010, MB=1.
  - C IN: MD=1, FS=0000.
  - D WAIT: NOP issued.
  - E reserved: NOP issued, illegal<=1.
  - F HALT: NOP issued.
- FSM states and transitions:
  - RUN: accepting. WAIT with imm=0 stays in RUN. WAIT with imm=N>0 goes to WAIT with cnt=N. HALT goes to HALTED.
  - WAIT: issues NOP. cnt decrements each cycle; at cnt==1 the next state is RUN. hold is ignored, and the counter keeps counting while hold=1.
  - HALTED: issues NOP, halted=1, instr_ready=0. Exit only via reset.
- WAIT N therefore yields N+1 NOP cycles and N cycles of instr_ready=0.
- hold=1 in RUN: no acceptance even if instr_valid=1, and NOP is issued the next cycle. The upstream side must keep instr stable.
- Reset mid-WAIT or in HALTED: returns to RUN, counter=0, and all flags are cleared.
- The illegal flag stays set until reset and does not stop execution.

Optional Feature:
- Macro PERF_CNT_EN.
- Defined: adds output issue_cnt [CNT_W-1:0].
  - Reset value is 0.
  - Increments on each accepted instruction with op in 1..C.
  - Wraps from all-ones to 0.
  - Holds in WAIT and HALTED.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then instr=16'h3D80 valid for 1 cycle -> next cycle ControlWord=13'h1B08, then NOP 13'h0001.
- instr=16'hA809 (LDI R2,#9) -> ControlWord=13'h1070, ConstantIn=4'h9. Through the datapath, Reg2=4'h9 after the following edge.
- instr=16'hD003 (WAIT 3) followed immediately by ADD -> 4 cycles of NOP, instr_ready low for 3 cycles, and ADD accepted on the 4th cycle after WAIT acceptance.
- hold=1 with instr_valid=1 for 2 cycles -> instr_ready=0, NOP for 2 cycles. Releasing hold -> accepted and issued next cycle.
- instr=16'hE000 then 16'h3D80 -> NOP, illegal=1 sticky, then ControlWord=13'h1B08. With PERF_CNT_EN, issue_cnt=1.
- instr=16'hF000 then nRST pulsed low 1 cycle -> halted=1 and instr_ready=0 until reset; after reset halted=0, ready=1, ControlWord=13'h0001.
